// File: rtl/gray_activity_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gray_activity_monitor: Gray-to-binary decoder with toggle/violation stats.
// Revision: 1.0
// ---------------------------------------------------------------------------
module gray_activity_monitor #(
   parameter int W  = 32,
   parameter int CW = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [W-1:0]         g,
   input  logic                 g_valid,
   input  logic                 clr,
   output logic [W-1:0]         bin,
   output logic                 bin_valid,
   output logic [CW-1:0]        samples,
   output logic [CW-1:0]        toggles,
   output logic [$clog2(W):0]   last_hd,
   output logic                 err,
   output logic [15:0]          err_count
);

   localparam int c_hw = $clog2(W) + 1;
   localparam int c_sw = ((CW > c_hw) ? CW : c_hw) + 1;
   localparam logic [CW-1:0] c_cnt_max = '1;

   logic [W-1:0]    prev_q, prev_d;
   logic            has_prev_q, has_prev_d;
   logic            s1_valid_q, s1_valid_d;
   logic            s1_first_q, s1_first_d;
   logic [W-1:0]    s1_g_q, s1_g_d;
   logic [c_hw-1:0] s1_hd_q, s1_hd_d;
   logic            s2_valid_q, s2_valid_d;
   logic            s2_first_q, s2_first_d;
   logic [W-1:0]    s2_bin_q, s2_bin_d;
   logic [c_hw-1:0] s2_hd_q, s2_hd_d;
   logic [W-1:0]    bin_q, bin_d;
   logic            bin_valid_q, bin_valid_d;
   logic [CW-1:0]   samples_q, samples_d;
   logic [CW-1:0]   toggles_q, toggles_d;
   logic [c_hw-1:0] last_hd_q, last_hd_d;
   logic            err_q, err_d;
   logic [15:0]     err_count_q, err_count_d;

   logic [W-1:0]    w_diff;
   logic [c_hw-1:0] w_hd;
   logic [W-1:0]    w_bin_dec;
   logic [c_sw-1:0] w_tog_sum;

   always_comb begin
      w_diff    = g ^ prev_q;
      w_hd      = '0;
      w_bin_dec = '0;
      for (int i = 0; i < W; i++) begin
         w_hd = w_hd + c_hw'(w_diff[i]);
      end
      w_bin_dec[W-1] = s1_g_q[W-1];
      for (int i = W - 2; i >= 0; i--) begin
         w_bin_dec[i] = w_bin_dec[i+1] ^ s1_g_q[i];
      end
      w_tog_sum = c_sw'(toggles_q) + c_sw'(s2_hd_q);

      prev_d      = prev_q;
      has_prev_d  = has_prev_q;
      s1_valid_d  = g_valid;
      s1_first_d  = s1_first_q;
      s1_g_d      = s1_g_q;
      s1_hd_d     = s1_hd_q;
      s2_valid_d  = s1_valid_q & ~clr;
      s2_first_d  = s2_first_q;
      s2_bin_d    = s2_bin_q;
      s2_hd_d     = s2_hd_q;
      bin_d       = bin_q;
      bin_valid_d = s2_valid_q & ~clr;
      samples_d   = samples_q;
      toggles_d   = toggles_q;
      last_hd_d   = last_hd_q;
      err_d       = err_q;
      err_count_d = err_count_q;

      // A sample arriving with clr still enters the pipe, but as a fresh first sample.
      if (g_valid) begin
         s1_g_d     = g;
         s1_first_d = clr | ~has_prev_q;
         s1_hd_d    = w_hd;
         prev_d     = g;
         has_prev_d = 1'b1;
      end else if (clr) begin
         has_prev_d = 1'b0;
      end

      if (s1_valid_q) begin
         s2_bin_d   = w_bin_dec;
         s2_first_d = s1_first_q;
         s2_hd_d    = s1_hd_q;
      end

      if (s2_valid_q && !clr) begin
         bin_d = s2_bin_q;
         if (samples_q != c_cnt_max) begin
            samples_d = samples_q + CW'(1);
         end
         if (s2_first_q) begin
            last_hd_d = '0;
         end else begin
            last_hd_d = s2_hd_q;
            toggles_d = (w_tog_sum > c_sw'(c_cnt_max)) ? c_cnt_max : w_tog_sum[CW-1:0];
            if (s2_hd_q != c_hw'(1)) begin
               err_d = 1'b1;
               if (err_count_q != 16'hFFFF) begin
                  err_count_d = err_count_q + 16'd1;
               end
            end
         end
      end

      if (clr) begin
         samples_d   = '0;
         toggles_d   = '0;
         last_hd_d   = '0;
         err_d       = 1'b0;
         err_count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q      <= '0;
         has_prev_q  <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_g_q      <= '0;
         s1_hd_q     <= '0;
         s2_valid_q  <= 1'b0;
         s2_first_q  <= 1'b0;
         s2_bin_q    <= '0;
         s2_hd_q     <= '0;
         bin_q       <= '0;
         bin_valid_q <= 1'b0;
         samples_q   <= '0;
         toggles_q   <= '0;
         last_hd_q   <= '0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         prev_q      <= prev_d;
         has_prev_q  <= has_prev_d;
         s1_valid_q  <= s1_valid_d;
         s1_first_q  <= s1_first_d;
         s1_g_q      <= s1_g_d;
         s1_hd_q     <= s1_hd_d;
         s2_valid_q  <= s2_valid_d;
         s2_first_q  <= s2_first_d;
         s2_bin_q    <= s2_bin_d;
         s2_hd_q     <= s2_hd_d;
         bin_q       <= bin_d;
         bin_valid_q <= bin_valid_d;
         samples_q   <= samples_d;
         toggles_q   <= toggles_d;
         last_hd_q   <= last_hd_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   assign bin       = bin_q;
   assign bin_valid = bin_valid_q;
   assign samples   = samples_q;
   assign toggles   = toggles_q;
   assign last_hd   = last_hd_q;
   assign err       = err_q;
   assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_activity_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gray_activity_monitor: directed self-checking bench for the monitor.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_gray_activity_monitor;

   logic        clk;
   logic        reset;
   logic [31:0] g;
   logic        g_valid;
   logic        clr;

   logic [31:0] bin,       bin4;
   logic        bin_valid, bin_valid4;
   logic [31:0] samples,   toggles;
   logic [3:0]  samples4,  toggles4;
   logic [5:0]  last_hd,   last_hd4;
   logic        err,       err4;
   logic [15:0] err_count, err_count4;

   int n_assert = 0;
   int n_fail   = 0;

   gray_activity_monitor #(.W(32), .CW(32)) dut (
      .clk(clk), .reset(reset), .g(g), .g_valid(g_valid), .clr(clr),
      .bin(bin), .bin_valid(bin_valid), .samples(samples), .toggles(toggles),
      .last_hd(last_hd), .err(err), .err_count(err_count)
   );

   gray_activity_monitor #(.W(32), .CW(4)) dut4 (
      .clk(clk), .reset(reset), .g(g), .g_valid(g_valid), .clr(clr),
      .bin(bin4), .bin_valid(bin_valid4), .samples(samples4), .toggles(toggles4),
      .last_hd(last_hd4), .err(err4), .err_count(err_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] gv, input logic vv, input logic cv);
      g       = gv;
      g_valid = vv;
      clr     = cv;
   endtask

   logic [31:0] gs [5];
   logic [31:0] k;

   initial begin
      gs = '{32'h0, 32'h1, 32'h3, 32'h2, 32'h6};
      reset = 1'b0;
      drive(32'h0, 1'b0, 1'b0);
      tick();
      tick();
      chk("rst_bin", bin, 0);
      chk("rst_bv", bin_valid, 0);
      chk("rst_samples", samples, 0);
      chk("rst_toggles", toggles, 0);
      chk("rst_last_hd", last_hd, 0);
      chk("rst_err", err, 0);
      chk("rst_err_count", err_count, 0);
      reset = 1'b1;

      // Consecutive legal Gray counts 0..4
      for (int i = 0; i < 7; i++) begin
         if (i < 5) drive(gs[i], 1'b1, 1'b0);
         else       drive(32'h0, 1'b0, 1'b0);
         tick();
         if (i >= 2) begin
            chk("seq_bv", bin_valid, 1);
            chk("seq_bin", bin, 64'(i - 2));
         end else begin
            chk("seq_bv_lat", bin_valid, 0);
         end
      end
      tick();
      chk("seq_bv_idle", bin_valid, 0);
      chk("seq_samples", samples, 5);
      chk("seq_toggles", toggles, 4);
      chk("seq_err", err, 0);
      chk("seq_last_hd", last_hd, 1);

      // Wrap-around from Gray of max back to zero
      drive(32'h0, 1'b0, 1'b1);
      tick();
      drive(32'h0, 1'b0, 1'b0);
      chk("clr_samples", samples, 0);
      chk("clr_toggles", toggles, 0);
      chk("clr_bv", bin_valid, 0);
      drive(32'h8000_0000, 1'b1, 1'b0);
      tick();
      drive(32'h0, 1'b1, 1'b0);
      tick();
      drive(32'h0, 1'b0, 1'b0);
      tick();
      chk("wrap_bin_max", bin, 64'hFFFF_FFFF);
      chk("wrap_bv_max", bin_valid, 1);
      chk("wrap_hd_first", last_hd, 0);
      tick();
      chk("wrap_bin_zero", bin, 0);
      chk("wrap_bv_zero", bin_valid, 1);
      chk("wrap_hd", last_hd, 1);
      chk("wrap_err", err, 0);

      // Violation, sticky err, then clr
      drive(32'h0, 1'b0, 1'b1);
      tick();
      drive(32'h1, 1'b1, 1'b0);
      tick();
      drive(32'h2, 1'b1, 1'b0);
      tick();
      drive(32'h6, 1'b1, 1'b0);
      tick();
      chk("viol_first_hd", last_hd, 0);
      drive(32'h0, 1'b0, 1'b0);
      tick();
      chk("viol_hd", last_hd, 2);
      chk("viol_err", err, 1);
      chk("viol_err_count", err_count, 1);
      tick();
      chk("sticky_hd", last_hd, 1);
      chk("sticky_err", err, 1);
      chk("sticky_err_count", err_count, 1);
      chk("sticky_samples", samples, 3);
      drive(32'h0, 1'b0, 1'b1);
      tick();
      drive(32'h0, 1'b0, 1'b0);
      chk("vclr_err", err, 0);
      chk("vclr_err_count", err_count, 0);
      chk("vclr_samples", samples, 0);
      chk("vclr_bv", bin_valid, 0);

      // Comparison spanning an idle gap
      drive(32'h1, 1'b1, 1'b0);
      tick();
      drive(32'hFF, 1'b0, 1'b0);
      tick();
      chk("gap_bv_a", bin_valid, 0);
      tick();
      chk("gap_bv_first", bin_valid, 1);
      chk("gap_bin_first", bin, 1);
      tick();
      chk("gap_bv_c", bin_valid, 0);
      drive(32'h3, 1'b1, 1'b0);
      tick();
      drive(32'hFF, 1'b0, 1'b0);
      chk("gap_bv_d", bin_valid, 0);
      tick();
      chk("gap_bv_e", bin_valid, 0);
      tick();
      chk("gap_bv_out", bin_valid, 1);
      chk("gap_bin", bin, 2);
      chk("gap_hd", last_hd, 1);
      chk("gap_toggles", toggles, 1);
      chk("gap_err", err, 0);
      chk("gap_samples", samples, 2);

      // Saturation on the CW=4 instance
      drive(32'h0, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 20; i++) begin
         k = 32'(i);
         drive(k ^ (k >> 1), 1'b1, 1'b0);
         tick();
      end
      drive(32'h0, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      chk("sat_samples4", samples4, 15);
      chk("sat_toggles4", toggles4, 15);
      chk("sat_err4", err4, 0);
      chk("sat_samples", samples, 20);
      chk("sat_toggles", toggles, 19);

      // Asynchronous reset mid-stream (history is Gray(19) = 0x1A)
      drive(32'h7, 1'b1, 1'b0);
      tick();
      drive(32'h5, 1'b1, 1'b0);
      tick();
      drive(32'h0, 1'b0, 1'b0);
      tick();
      chk("pre_rst_hd", last_hd, 4);
      chk("pre_rst_err", err, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_bin", bin, 0);
      chk("arst_bv", bin_valid, 0);
      chk("arst_samples", samples, 0);
      chk("arst_toggles", toggles, 0);
      chk("arst_last_hd", last_hd, 0);
      chk("arst_err", err, 0);
      chk("arst_err_count", err_count, 0);
      chk("arst_samples4", samples4, 0);
      tick();
      #2;
      reset = 1'b1;
      drive(32'h9, 1'b1, 1'b0);
      tick();
      drive(32'h0, 1'b0, 1'b0);
      tick();
      chk("post_rst_bv_a", bin_valid, 0);
      tick();
      chk("post_rst_bv", bin_valid, 1);
      chk("post_rst_bin", bin, 64'hE);
      chk("post_rst_hd", last_hd, 0);
      chk("post_rst_err", err, 0);
      chk("post_rst_samples", samples, 1);
      chk("post_rst_err_count", err_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gray_activity_monitor.md
GRAY_ACTIVITY_MONITOR -- requirements
Module: gray_activity_monitor

Interface
REQ-001 SHALL have parameter W, default 32: width of the Gray-coded count input and the decoded output.
REQ-002 SHALL have parameter CW, default 32: width of the samples and toggles statistics counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port g  input  W  Gray-coded count from the upstream gcounter stage.
REQ-006 SHALL have port g_valid  input  1  qualifies g; g is ignored when 0.
REQ-007 SHALL have port clr  input  1  synchronous clear of statistics and history.
REQ-008 SHALL have port bin  output  W  registered binary decode of g.
REQ-009 SHALL have port bin_valid  output  1  marks the cycle in which bin carries a new decoded sample.
REQ-010 SHALL have port samples  output  CW  saturating count of accepted samples.
REQ-011 SHALL have port toggles  output  CW  saturating sum of bits toggled between consecutive accepted samples (power proxy).
REQ-012 SHALL have port last_hd  output  $clog2(W)+1  Hamming distance of the most recent compared pair.
REQ-013 SHALL have port err  output  1  sticky Gray-property violation flag.
REQ-014 SHALL have port err_count  output  16  saturating count of violations.

Function
REQ-015 SHALL accept a sample on each rising edge where g_valid=1; two-stage pipeline: stage 1 registers g, stage 2 produces outputs.
REQ-016 SHALL present bin and bin_valid=1 exactly 2 rising edges after the accepting edge; bin_valid=0 in all other cycles.
REQ-017 SHALL decode as bin[W-1]=g[W-1] and bin[i]=bin[i+1] XOR g[i] for i<W-1.
REQ-018 SHALL hold a history register with the last accepted sample and a has_prev flag; the history is unchanged when g_valid=0, so comparisons span idle gaps.
REQ-019 SHALL, for an accepted sample with has_prev=1, compute hd=popcount(g XOR prev), update last_hd=hd, and add hd to toggles, in the same stage-2 cycle as bin_valid.
REQ-020 SHALL treat hd!=1 (including hd=0, a repeated value) as a violation: set err=1 and increment err_count.
REQ-021 SHALL, for an accepted sample with has_prev=0, do no compare: last_hd=0, toggles and err unchanged; samples still increments.
REQ-022 SHALL treat wrap-around 2^(W-1) (Gray of max) -> 0 as a legal single-bit change.
REQ-023 SHALL saturate samples and toggles at 2^CW-1 and err_count at 65535; toggles saturates on overflow of the addition rather than wrapping.
REQ-024 SHALL hold err at 1 until reset or clr.
REQ-025 SHALL, on clr=1 at an edge: zero samples, toggles, last_hd, err and err_count; clear has_prev; flush in-flight stage-1 and stage-2 data so bin_valid=0 on the next cycle.
REQ-026 SHALL, on clr=1 coinciding with g_valid=1: clr has priority for statistics; that sample is accepted as a new first sample (has_prev=0 semantics) and emerges 2 edges later.
REQ-027 SHALL leave bin holding its last value while bin_valid=0.

Reset
REQ-028 SHALL, while reset=0, asynchronously force bin, bin_valid, samples, toggles, last_hd, err, err_count, has_prev and all pipeline valids to 0, with no clock edge required.
REQ-029 SHALL, after reset deasserts, treat the first accepted sample as a first sample (no compare); reset mid-stream drops all in-flight samples.

Verification
REQ-030 SHALL cover: reset, then g=0,1,3,2,6 with g_valid=1 on consecutive edges -> bin=0,1,2,3,4 with bin_valid=1 on edges 3..7; final samples=5, toggles=4, err=0.
REQ-031 SHALL cover: g=0x80000000 then 0x00000000 -> bin=0xFFFFFFFF then 0x00000000, last_hd=1, err=0.
REQ-032 SHALL cover: g=0x1 then 0x2 -> last_hd=2, err=1, err_count=1; subsequent g=0x6 keeps err=1 with err_count=1; clr pulse -> err=0, err_count=0, samples=0.
REQ-033 SHALL cover: g=0x1, three idle cycles (g_valid=0, g=0xFF), g=0x3 -> bin_valid low during gap, last_hd=1, toggles=1, err=0.
REQ-034 SHALL cover: CW=4 instance fed 20 legal Gray samples -> samples=15, toggles=15, no wrap.
REQ-035 SHALL cover: reset driven 0 mid-stream between clock edges -> all outputs 0 immediately; after release, next sample gives last_hd=0, err=0.
